// File: rtl/alu_seq.sv
// alu_seq: command-side sequencer for the 8-bit combinational ALU.
//
// Takes requests on a valid/ready command port and runs them through the ALU
// in one pass (8-bit) or two passes (16-bit, low byte then high byte). The
// results come back on a valid/ready response port. For arithmetic ops the
// carry is chained from the low pass into the high pass. For logic and shift
// ops each byte is handled on its own.
//
// Optional build macro: ALU_SEQ_STATS_EN. When it is defined, op_count counts
// completed responses and saturates at 16'hFFFF. When it is not defined,
// op_count is tied to zero.
//
// Ports:
//   clk, rst_n              clock and synchronous active-low reset
//   cmd_valid/cmd_ready     request handshake
//   cmd_op/a/b/cin/wide     request fields (ALU select, operands, carry-in, width)
//   alu_a/b/s/cin           registered drives into the ALU
//   alu_d/cout/z            combinational results from the ALU
//   rsp_valid/rsp_ready     response handshake
//   rsp_data/cout/zero      response fields
//   op_count                completed-op counter
//
// state | meaning
// IDLE  | ready for a request; ALU drives held at zero
// LO    | low-byte pass on the ALU
// HI    | high-byte pass on the ALU (wide ops only)
// RESP  | response presented, waiting for rsp_ready
module alu_seq #(
  parameter logic [1:0] ARITH_SEL = 2'b00,
  parameter bit         ZERO_SRC  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic        cmd_cin,
  input  logic        cmd_wide,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_s,
  output logic        alu_cin,
  input  logic [7:0]  alu_d,
  input  logic        alu_cout,
  input  logic        alu_z,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_cout,
  output logic        rsp_zero,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI, ST_RESP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  a_hi_q, a_hi_d;
  logic [7:0]  b_hi_q, b_hi_d;
  logic        cin_q, cin_d;
  logic        wide_q, wide_d;
  logic [7:0]  alu_a_q, alu_a_d;
  logic [7:0]  alu_b_q, alu_b_d;
  logic [3:0]  alu_s_q, alu_s_d;
  logic        alu_cin_q, alu_cin_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_cout_q, rsp_cout_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        pass_zero;

  always_comb begin
    state_d    = state_q;
    a_hi_d     = a_hi_q;
    b_hi_d     = b_hi_q;
    cin_d      = cin_q;
    wide_d     = wide_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_s_d    = alu_s_q;
    alu_cin_d  = alu_cin_q;
    rsp_data_d = rsp_data_q;
    rsp_cout_d = rsp_cout_q;
    rsp_zero_d = rsp_zero_q;
    pass_zero  = ZERO_SRC ? alu_z : (alu_d == 8'h00);

    case (state_q)
      ST_IDLE: begin
        alu_a_d   = 8'h00;
        alu_b_d   = 8'h00;
        alu_s_d   = 4'h0;
        alu_cin_d = 1'b0;
        if (cmd_valid) begin
          state_d   = ST_LO;
          // The ALU drives are registered, so the low-pass operands are
          // loaded here and are already stable for the whole LO cycle.
          alu_a_d   = cmd_a[7:0];
          alu_b_d   = cmd_b[7:0];
          alu_s_d   = cmd_op;
          alu_cin_d = cmd_cin;
          a_hi_d    = cmd_a[15:8];
          b_hi_d    = cmd_b[15:8];
          cin_d     = cmd_cin;
          wide_d    = cmd_wide;
        end
      end
      ST_LO: begin
        rsp_data_d = {8'h00, alu_d};
        rsp_cout_d = alu_cout;
        rsp_zero_d = pass_zero;
        if (wide_q) begin
          state_d   = ST_HI;
          alu_a_d   = a_hi_q;
          alu_b_d   = b_hi_q;
          alu_cin_d = (alu_s_q[3:2] == ARITH_SEL) ? alu_cout : cin_q;
        end else begin
          state_d   = ST_RESP;
          alu_a_d   = 8'h00;
          alu_b_d   = 8'h00;
          alu_s_d   = 4'h0;
          alu_cin_d = 1'b0;
        end
      end
      ST_HI: begin
        rsp_data_d = {alu_d, rsp_data_q[7:0]};
        rsp_cout_d = alu_cout;
        rsp_zero_d = rsp_zero_q & pass_zero;
        state_d    = ST_RESP;
        alu_a_d    = 8'h00;
        alu_b_d    = 8'h00;
        alu_s_d    = 4'h0;
        alu_cin_d  = 1'b0;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      a_hi_q     <= 8'h00;
      b_hi_q     <= 8'h00;
      cin_q      <= 1'b0;
      wide_q     <= 1'b0;
      alu_a_q    <= 8'h00;
      alu_b_q    <= 8'h00;
      alu_s_q    <= 4'h0;
      alu_cin_q  <= 1'b0;
      rsp_data_q <= 16'h0000;
      rsp_cout_q <= 1'b0;
      rsp_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_hi_q     <= a_hi_d;
      b_hi_q     <= b_hi_d;
      cin_q      <= cin_d;
      wide_q     <= wide_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_s_q    <= alu_s_d;
      alu_cin_q  <= alu_cin_d;
      rsp_data_q <= rsp_data_d;
      rsp_cout_q <= rsp_cout_d;
      rsp_zero_q <= rsp_zero_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_s     = alu_s_q;
  assign alu_cin   = alu_cin_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_zero  = rsp_zero_q;

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (state_q == ST_RESP && rsp_ready && op_count_q != 16'hFFFF)
      op_count_d = op_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) op_count_q <= 16'h0000;
    else        op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
`else
  assign op_count = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_a, cmd_b;
  logic        cmd_cin, cmd_wide;
  logic [7:0]  alu_a, alu_b, alu_d;
  logic [3:0]  alu_s;
  logic        alu_cin, alu_cout, alu_z;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data, op_count;
  logic        rsp_cout, rsp_zero;

  int total = 0;
  int bad   = 0;
  int ops_done = 0;

  always #5 clk = ~clk;

  alu_seq dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_wide(cmd_wide),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin),
    .alu_d(alu_d), .alu_cout(alu_cout), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .op_count(op_count)
  );

  // ALU stub: 00xx arithmetic, 01xx logic, 10xx shift right, 11xx shift left.
  logic [8:0] stub_sum;
  always_comb begin
    stub_sum = 9'h000;
    alu_d    = 8'h00;
    alu_cout = 1'b0;
    case (alu_s[3:2])
      2'b00: begin
        case (alu_s[1:0])
          2'b00: stub_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
          2'b01: stub_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'h00, alu_cin};
          2'b10: stub_sum = {1'b0, alu_a} + {8'h00, alu_cin};
          default: stub_sum = {1'b0, alu_a} + 9'h0FF + {8'h00, alu_cin};
        endcase
        alu_d    = stub_sum[7:0];
        alu_cout = stub_sum[8];
      end
      2'b01: begin
        case (alu_s[1:0])
          2'b00: alu_d = alu_a & alu_b;
          2'b01: alu_d = alu_a | alu_b;
          2'b10: alu_d = alu_a ^ alu_b;
          default: alu_d = ~alu_a;
        endcase
      end
      2'b10: begin
        alu_d    = {1'b0, alu_a[7:1]};
        alu_cout = alu_a[0];
      end
      default: begin
        alu_d    = {alu_a[6:0], 1'b0};
        alu_cout = alu_a[7];
      end
    endcase
    alu_z = (alu_d == 8'h00);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model at operand width: arithmetic is one 16- or 8-bit sum, shifts act per byte.
  task automatic ref_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic wide,
                           output logic [15:0] d, output logic co, output logic z);
    int unsigned mask, w, av, bv, s;
    logic [7:0] lo, hi;
    w    = wide ? 16 : 8;
    mask = wide ? 32'hFFFF : 32'hFF;
    av   = a & mask;
    bv   = b & mask;
    co   = 1'b0;
    d    = 16'h0000;
    case (op[3:2])
      2'b00: begin
        case (op[1:0])
          2'b00: s = av + bv + cin;
          2'b01: s = av + (~bv & mask) + cin;
          2'b10: s = av + cin;
          default: s = av + mask + cin;
        endcase
        d  = 16'(s & mask);
        co = ((s >> w) & 1) != 0;
      end
      2'b01: begin
        case (op[1:0])
          2'b00: s = av & bv;
          2'b01: s = av | bv;
          2'b10: s = av ^ bv;
          default: s = ~av;
        endcase
        d = 16'(s & mask);
      end
      2'b10: begin
        lo = a[7:0] >> 1;
        hi = wide ? (a[15:8] >> 1) : 8'h00;
        d  = {hi, lo};
        co = wide ? a[8] : a[0];
      end
      default: begin
        lo = a[7:0] << 1;
        hi = wide ? (a[15:8] << 1) : 8'h00;
        d  = {hi, lo};
        co = wide ? a[15] : a[7];
      end
    endcase
    z = (d == 16'h0000);
  endtask

  function automatic logic [15:0] exp_count();
`ifdef ALU_SEQ_STATS_EN
    return (ops_done > 65535) ? 16'hFFFF : 16'(ops_done);
`else
    return 16'h0000;
`endif
  endfunction

  // Issue one op from IDLE (called #1 after a rising edge), hold the
  // response for 'hold' cycles, optionally poking a competing request.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic wide, input int hold, input bit poke);
    logic [15:0] ed, ld;
    logic ec, ez, lc, lz;
    int lat;
    ref_model(op, a, b, cin, wide, ed, ec, ez);
    ref_model(op, a, b, cin, 1'b0, ld, lc, lz);
    chk("idle_ready", cmd_ready, 1);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_wide = wide;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      if (lat == 1) begin
        chk("lo_a", alu_a, a[7:0]);
        chk("lo_s", alu_s, op);
        chk("lo_cin", alu_cin, cin);
      end
      if (lat == 2) begin
        chk("hi_a", alu_a, a[15:8]);
        chk("hi_b", alu_b, b[15:8]);
        chk("hi_cin", alu_cin, (op[3:2] == 2'b00) ? lc : cin);
      end
      chk("busy_ready", cmd_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, wide ? 3 : 2);
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_ready", cmd_ready, 0);
      chk("hold_data", rsp_data, ed);
      chk("hold_cout", rsp_cout, ec);
      chk("hold_zero", rsp_zero, ez);
      if (poke) begin
        cmd_op = ~op; cmd_a = ~a; cmd_b = ~b; cmd_wide = ~wide;
        cmd_valid = 1'b1;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk("rsp_data", rsp_data, ed);
    chk("rsp_cout", rsp_cout, ec);
    chk("rsp_zero", rsp_zero, ez);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    ops_done++;
    chk("post_valid", rsp_valid, 0);
    chk("post_ready", cmd_ready, 1);
    chk("op_count", op_count, exp_count());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = 4'h0; cmd_a = 16'h0; cmd_b = 16'h0; cmd_cin = 1'b0; cmd_wide = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_cout", rsp_cout, 0);
    chk("rst_zero", rsp_zero, 0);
    chk("rst_alu", {alu_a, alu_b, alu_s, alu_cin}, 0);
    chk("rst_count", op_count, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases from the plan.
    run_op(4'b0000, 16'h00F0, 16'h0020, 1'b0, 1'b0, 0, 1'b0);
    run_op(4'b0000, 16'h12FF, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
    run_op(4'b1000, 16'h9696, 16'h0000, 1'b0, 1'b1, 0, 1'b0);
    run_op(4'b1100, 16'h0096, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
    run_op(4'b0000, 16'h00FF, 16'h0001, 1'b0, 1'b0, 5, 1'b1);
    run_op(4'b0000, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 2, 1'b0);
    run_op(4'b0101, 16'h1234, 16'h00F0, 1'b1, 1'b1, 1, 1'b0);

    // Reset during the HI pass of a wide op.
    cmd_op = 4'b0000; cmd_a = 16'hA5C3; cmd_b = 16'h3C5A; cmd_cin = 1'b1; cmd_wide = 1'b1;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_hi_a", alu_a, 8'hA5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    ops_done = 0;
    chk("rr_ready", cmd_ready, 1);
    chk("rr_valid", rsp_valid, 0);
    chk("rr_alu", {alu_a, alu_b, alu_s, alu_cin}, 0);
    chk("rr_data", rsp_data, 0);
    chk("rr_count", op_count, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("rr_no_rsp", rsp_valid, 0);
    end

    // Randomized ops against the reference model.
    for (int n = 0; n < 40; n++) begin
      run_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    chk("final_count", op_count, exp_count());
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Command-side driver for the 8-bit gate-level ALU. It owns the ALU's A/B/S/C_in inputs and captures D/C_out/z.
- It accepts operation requests over a valid/ready handshake and sequences one pass (8-bit) or two passes (16-bit, carry chained low→high) through the combinational ALU.
- Results are returned over a second valid/ready handshake.
- It sits between the control/decode logic and the ALU instance.

Parameters:
- ARITH_SEL, 2'b00, value of S[3:2] that selects the arithmetic unit. Carry is chained between passes only for this value.
- ZERO_SRC, 0, zero-flag source. 0 = local NOR of the captured result bytes; 1 = alu_z from each pass, ANDed across passes.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  request valid
- cmd_ready  out  1  sequencer can accept a request
- cmd_op  in  4  ALU select S[3:0]
- cmd_a  in  16  operand A; only [7:0] used when narrow
- cmd_b  in  16  operand B; only [7:0] used when narrow
- cmd_cin  in  1  carry-in for the first pass
- cmd_wide  in  1  1 = 16-bit two-pass, 0 = 8-bit single pass
- alu_a  out  8  to ALU A
- alu_b  out  8  to ALU B
- alu_s  out  4  to ALU S
- alu_cin  out  1  to ALU C_in
- alu_d  in  8  from ALU D
- alu_cout  in  1  from ALU C_out
- alu_z  in  1  from ALU z
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  16  result; [15:8] = 0 for narrow ops
- rsp_cout  out  1  carry-out of the final pass
- rsp_zero  out  1  zero flag
- op_count  out  16  completed-op counter (see Optional Feature)

Behaviour:
- Single clock domain. All state is updated on the clk rising edge. rst_n is synchronous and active-low.
- Reset values: state = IDLE, cmd_ready = 1, rsp_valid = 0, rsp_data = 0, rsp_cout = 0, rsp_zero = 0, alu_a = alu_b = 0, alu_s = 0, alu_cin = 0, op_count = 0.
- FSM states: IDLE, LO, HI, RESP.
- IDLE:
  - cmd_ready = 1.
  - If cmd_valid, register op/a/b/cin/wide and go to LO.
  - ALU drive outputs held at 0.
- LO:
  - Drive alu_a = a[7:0], alu_b = b[7:0], alu_s = op, alu_cin = cin.
  - At the clock edge, capture alu_d into rsp_data[7:0], plus alu_cout and alu_z.
  - Next state: HI if wide, else RESP.
- HI:
  - Drive alu_a = a[15:8], alu_b = b[15:8], alu_s = op.
  - alu_cin = captured LO carry when op[3:2] == ARITH_SEL; otherwise the original cin.
  - Capture alu_d into rsp_data[15:8]. Go to RESP.
  - Logic and shift ops operate on each byte independently. No bit crosses between bytes on shifts (16-bit shifts are not supported).
- RESP:
  - rsp_valid = 1. rsp_data, rsp_cout and rsp_zero are stable while rsp_valid && !rsp_ready.
  - On rsp_ready, go to IDLE with rsp_valid = 0.
  - cmd_ready is 0 in LO/HI/RESP (no overlap of requests).
- ALU outputs are registered drives. The ALU is purely combinational, so each pass costs exactly one cycle.
- Latency, from the cmd accept edge to rsp_valid high:
  - 2 cycles narrow (edge0 accept, LO cycle 1, RESP cycle 2).
  - 3 cycles wide.
  - Back-to-back throughput: one op per 3 cycles (narrow) or 4 cycles (wide), with rsp_ready held high.
- Zero flag:
  - ZERO_SRC = 0: narrow = (d[7:0] == 0); wide = (d[15:0] == 0).
  - ZERO_SRC = 1: AND of alu_z over the passes executed.
- rsp_cout = alu_cout of the final pass.
- Reset asserted in any state: the in-flight op is discarded, no response is issued, and all outputs return to their reset values on the next edge.
- cmd_valid while not in IDLE is ignored; the requester must hold the request.
- In IDLE, rsp_ready is don't-care.

Optional Feature:
- Macro ALU_SEQ_STATS_EN.
- Defined: op_count increments by 1 on each RESP→IDLE handshake and saturates at 16'hFFFF. It is cleared by reset.
- Undefined: no counter logic is built and op_count is tied to 16'h0000.

Test Plan:
- The bench ALU stub computes op 4'b0000 as A+B+C_in, z = (sum == 0). Narrow add with a=0x00F0, b=0x0020, cin=0 → rsp_valid 2 cycles after accept, rsp_data = 0x0010, rsp_cout = 1, rsp_zero = 0.
- Wide add with a=0x12FF, b=0x0001, cin=0 → alu_cin = 1 in HI, rsp_data = 0x1300, rsp_cout = 0, rsp_zero = 0, rsp_valid 3 cycles after accept.
- Wide shift right, op 4'b1000, a=0x9696 → rsp_data = 0x4B4B (no cross-byte bit). Narrow shift left, op 4'b1100, a=0x0096 → 0x002C.
- Hold rsp_ready = 0 for 5 cycles in RESP → rsp_data and flags stable, cmd_ready = 0. A new cmd_valid during this time is not accepted until rsp_ready is taken.
- Drop rst_n during HI of a wide op → next edge: IDLE, rsp_valid = 0, ALU drives = 0, no response ever appears for that op.
- With ALU_SEQ_STATS_EN: 3 completed ops → op_count = 3. Preloaded at 16'hFFFF, one more op → op_count stays 16'hFFFF. Without the macro, op_count = 0 throughout.
